// File: rtl/lc4_operand_issue.sv
// rtl/lc4_operand_issue.sv - LC4 operand-issue stage: register file, source decode, ALU operand register
// Purpose: holds the 8x16 LC4 register file, decodes source registers from the
//   incoming instruction and presents registered insn/pc/operands to lc4_alu
//   behind a valid/ready handshake.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_valid/o_ready            upstream handshake; i_insn, i_pc from fetch
//   o_valid/i_ready            downstream handshake
//   o_insn, o_pc               registered instruction and PC
//   o_r1data/o_r2data          registered operands
//   o_r1sel/o_r2sel            register indices behind the operands
//   i_wb_we/i_wb_sel/i_wb_data writeback port from the last stage
// Configuration: define LC4_ISSUE_BYPASS_EN to forward same-edge writeback into
//   accepted and held operands.
module lc4_operand_issue #(
  parameter int          NREGS    = 8,
  parameter logic [15:0] RESET_PC = 16'h8200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_insn,
  input  logic [15:0] i_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_insn,
  output logic [15:0] o_pc,
  output logic [15:0] o_r1data,
  output logic [15:0] o_r2data,
  output logic [2:0]  o_r1sel,
  output logic [2:0]  o_r2sel,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_sel,
  input  logic [15:0] i_wb_data
);

  // NREGS is fixed at 8 by the ISA; 3-bit selects index the whole file.
  logic [15:0] regs [NREGS];

  logic [2:0]  r1sel_d;
  logic [2:0]  r2sel_d;
  logic [15:0] r1read;
  logic [15:0] r2read;
  logic        accept;
  logic        drain;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  assign drain   = o_valid && i_ready;

  // Decode applies to every opcode so unused operand fields still give
  // deterministic register selections.
  always_comb begin
    r1sel_d = i_insn[8:6];
    r2sel_d = i_insn[2:0];
    case (i_insn[15:12])
      4'b0010, 4'b1101: r1sel_d = i_insn[11:9];
      4'b1000:          r1sel_d = 3'd7;
      default:          r1sel_d = i_insn[8:6];
    endcase
    if (i_insn[15:12] == 4'b0111) begin
      r2sel_d = i_insn[11:9];
    end
  end

  always_comb begin
    r1read = regs[r1sel_d];
    r2read = regs[r2sel_d];
`ifdef LC4_ISSUE_BYPASS_EN
    if (i_wb_we && (i_wb_sel == r1sel_d)) begin
      r1read = i_wb_data;
    end
    if (i_wb_we && (i_wb_sel == r2sel_d)) begin
      r2read = i_wb_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      o_valid  <= 1'b0;
      o_insn   <= '0;
      o_pc     <= RESET_PC;
      o_r1data <= '0;
      o_r2data <= '0;
      o_r1sel  <= '0;
      o_r2sel  <= '0;
    end else begin
      if (i_wb_we) begin
        regs[i_wb_sel] <= i_wb_data;
      end
      if (accept) begin
        o_valid  <= 1'b1;
        o_insn   <= i_insn;
        o_pc     <= i_pc;
        o_r1sel  <= r1sel_d;
        o_r2sel  <= r2sel_d;
        o_r1data <= r1read;
        o_r2data <= r2read;
      end else if (drain) begin
        // Data registers keep their values; only the valid flag drops.
        o_valid <= 1'b0;
      end else if (o_valid) begin
`ifdef LC4_ISSUE_BYPASS_EN
        // Held operands follow writeback so they always match the register file.
        if (i_wb_we && (i_wb_sel == o_r1sel)) begin
          o_r1data <= i_wb_data;
        end
        if (i_wb_we && (i_wb_sel == o_r2sel)) begin
          o_r2data <= i_wb_data;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_lc4_operand_issue.sv
// tb/tb_lc4_operand_issue.sv - directed self-checking bench for lc4_operand_issue
module tb_lc4_operand_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_insn;
  logic [15:0] i_pc;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_insn;
  logic [15:0] o_pc;
  logic [15:0] o_r1data;
  logic [15:0] o_r2data;
  logic [2:0]  o_r1sel;
  logic [2:0]  o_r2sel;
  logic        i_wb_we;
  logic [2:0]  i_wb_sel;
  logic [15:0] i_wb_data;

  int tests = 0;
  int fails = 0;

`ifdef LC4_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  lc4_operand_issue dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_insn    (i_insn),
    .i_pc      (i_pc),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_insn    (o_insn),
    .o_pc      (o_pc),
    .o_r1data  (o_r1data),
    .o_r2data  (o_r2data),
    .o_r1sel   (o_r1sel),
    .o_r2sel   (o_r2sel),
    .i_wb_we   (i_wb_we),
    .i_wb_sel  (i_wb_sel),
    .i_wb_data (i_wb_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_insn = '0; i_pc = '0; i_ready = 1'b1;
    i_wb_we = 1'b0; i_wb_sel = '0; i_wb_data = '0;
    step(); step();
    rst = 1'b0;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %h expected %h", o_valid, 1'b0); end
    tests++; if (o_pc !== 16'h8200) begin fails++; $display("FAIL reset_pc: got %h expected %h", o_pc, 16'h8200); end
    tests++; if (o_insn !== 16'h0000) begin fails++; $display("FAIL reset_insn: got %h expected %h", o_insn, 16'h0000); end
    tests++; if ({o_r1data, o_r2data} !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected %h", {o_r1data, o_r2data}, 32'h0); end
    tests++; if ({o_r1sel, o_r2sel} !== 6'h0) begin fails++; $display("FAIL reset_sel: got %h expected %h", {o_r1sel, o_r2sel}, 6'h0); end
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %h expected %h", o_ready, 1'b1); end
  endtask

  task automatic test_first_issue();
    i_valid = 1'b1; i_insn = 16'h1042; i_pc = 16'h8200;
    step();
    i_valid = 1'b0;
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL t1_valid: got %h expected %h", o_valid, 1'b1); end
    tests++; if (o_insn !== 16'h1042) begin fails++; $display("FAIL t1_insn: got %h expected %h", o_insn, 16'h1042); end
    tests++; if (o_r1sel !== 3'd1 || o_r2sel !== 3'd2) begin fails++; $display("FAIL t1_sel: got %0d,%0d expected 1,2", o_r1sel, o_r2sel); end
    tests++; if ({o_r1data, o_r2data} !== 32'h0) begin fails++; $display("FAIL t1_data: got %h expected %h", {o_r1data, o_r2data}, 32'h0); end
    step();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL t1_drain_valid: got %h expected %h", o_valid, 1'b0); end
    tests++; if (o_insn !== 16'h1042) begin fails++; $display("FAIL t1_drain_keep: got %h expected %h", o_insn, 16'h1042); end
  endtask

  task automatic test_wb_then_issue();
    i_wb_we = 1'b1; i_wb_sel = 3'd1; i_wb_data = 16'h0005;
    step();
    i_wb_sel = 3'd2; i_wb_data = 16'hFFFD;
    step();
    i_wb_we = 1'b0;
    i_valid = 1'b1; i_insn = 16'h1642; i_pc = 16'h8202;
    step();
    i_valid = 1'b0;
    tests++; if (o_r1data !== 16'h0005) begin fails++; $display("FAIL t2_r1: got %h expected %h", o_r1data, 16'h0005); end
    tests++; if (o_r2data !== 16'hFFFD) begin fails++; $display("FAIL t2_r2: got %h expected %h", o_r2data, 16'hFFFD); end
    tests++; if (o_pc !== 16'h8202) begin fails++; $display("FAIL t2_pc: got %h expected %h", o_pc, 16'h8202); end
    tests++; if (16'(o_r1data + o_r2data) !== 16'h0002) begin fails++; $display("FAIL t2_sum: got %h expected %h", 16'(o_r1data + o_r2data), 16'h0002); end
    step();
  endtask

  task automatic test_same_cycle();
    logic [15:0] exp_r1;
    exp_r1 = BYP ? 16'h1234 : 16'h0000;
    i_valid = 1'b1; i_insn = 16'h5108; i_pc = 16'h8204;
    i_wb_we = 1'b1; i_wb_sel = 3'd4; i_wb_data = 16'h1234;
    step();
    i_valid = 1'b0; i_wb_we = 1'b0;
    tests++; if (o_r1sel !== 3'd4 || o_r2sel !== 3'd0) begin fails++; $display("FAIL t3_sel: got %0d,%0d expected 4,0", o_r1sel, o_r2sel); end
    tests++; if (o_r1data !== exp_r1) begin fails++; $display("FAIL t3_r1: got %h expected %h", o_r1data, exp_r1); end
    tests++; if (o_r2data !== 16'h0000) begin fails++; $display("FAIL t3_r2: got %h expected %h", o_r2data, 16'h0000); end
    step();
  endtask

  task automatic test_stall();
    logic [15:0] exp_r1;
    exp_r1 = BYP ? 16'h0007 : 16'h0000;
    i_valid = 1'b1; i_insn = 16'h2A06; i_pc = 16'h8300; i_ready = 1'b1;
    step();
    tests++; if (o_r1sel !== 3'd5 || o_r2sel !== 3'd6) begin fails++; $display("FAIL t4_sel: got %0d,%0d expected 5,6", o_r1sel, o_r2sel); end
    i_ready = 1'b0; i_insn = 16'h1E49; i_pc = 16'h8301;
    i_wb_we = 1'b1; i_wb_sel = 3'd5; i_wb_data = 16'h0007;
    #1;
    tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL t4_ready0: got %h expected %h", o_ready, 1'b0); end
    for (int c = 0; c < 3; c++) begin
      step();
      i_wb_we = 1'b0;
      tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL t4_ready_c%0d: got %h expected %h", c, o_ready, 1'b0); end
      tests++; if (o_insn !== 16'h2A06 || o_pc !== 16'h8300) begin fails++; $display("FAIL t4_hold_c%0d: got %h/%h expected 2a06/8300", c, o_insn, o_pc); end
      tests++; if (o_r1sel !== 3'd5) begin fails++; $display("FAIL t4_r1sel_c%0d: got %0d expected 5", c, o_r1sel); end
      tests++; if (o_r1data !== exp_r1) begin fails++; $display("FAIL t4_r1data_c%0d: got %h expected %h", c, o_r1data, exp_r1); end
    end
    i_ready = 1'b1;
    #1;
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL t4_ready1: got %h expected %h", o_ready, 1'b1); end
    step();
    i_valid = 1'b0;
    tests++; if (o_valid !== 1'b1 || o_insn !== 16'h1E49) begin fails++; $display("FAIL t4_next: got %h/%h expected 1/1e49", o_valid, o_insn); end
    tests++; if (o_r1data !== 16'h0005 || o_r2data !== 16'h0005) begin fails++; $display("FAIL t4_next_data: got %h/%h expected 0005/0005", o_r1data, o_r2data); end
    step();
  endtask

  task automatic test_back_to_back();
    i_wb_we = 1'b1; i_wb_sel = 3'd7; i_wb_data = 16'hABCD;
    step();
    i_wb_we = 1'b0;
    i_valid = 1'b1; i_insn = 16'h7680; i_pc = 16'h8400;
    step();
    tests++; if (o_r1sel !== 3'd2 || o_r2sel !== 3'd3) begin fails++; $display("FAIL t5_str_sel: got %0d,%0d expected 2,3", o_r1sel, o_r2sel); end
    tests++; if (o_r1data !== 16'hFFFD || o_r2data !== 16'h0000) begin fails++; $display("FAIL t5_str_data: got %h/%h expected fffd/0000", o_r1data, o_r2data); end
    i_insn = 16'h8000; i_pc = 16'h8401;
    step();
    i_valid = 1'b0;
    tests++; if (o_valid !== 1'b1 || o_insn !== 16'h8000) begin fails++; $display("FAIL t5_rti_insn: got %h/%h expected 1/8000", o_valid, o_insn); end
    tests++; if (o_r1sel !== 3'd7) begin fails++; $display("FAIL t5_rti_sel: got %0d expected 7", o_r1sel); end
    tests++; if (o_r1data !== 16'hABCD) begin fails++; $display("FAIL t5_rti_data: got %h expected %h", o_r1data, 16'hABCD); end
    step();
  endtask

  task automatic test_reset_midflight();
    logic [15:0] insn;
    i_valid = 1'b1; i_insn = 16'h1042; i_pc = 16'h8500;
    step();
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL t6_pre_valid: got %h expected %h", o_valid, 1'b1); end
    rst = 1'b1; i_wb_we = 1'b1; i_wb_sel = 3'd3; i_wb_data = 16'h9999;
    step();
    rst = 1'b0; i_wb_we = 1'b0; i_valid = 1'b0;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL t6_valid: got %h expected %h", o_valid, 1'b0); end
    tests++; if (o_pc !== 16'h8200) begin fails++; $display("FAIL t6_pc: got %h expected %h", o_pc, 16'h8200); end
    for (int r = 0; r < 8; r++) begin
      insn = {4'b0001, 3'd0, 3'(r), 3'd0, 3'(r)};
      i_valid = 1'b1; i_insn = insn; i_pc = 16'h8600 + 16'(r);
      step();
      tests++; if (o_r1sel !== 3'(r) || o_r1data !== 16'h0 || o_r2data !== 16'h0) begin fails++; $display("FAIL t6_reg%0d: got sel %0d data %h/%h expected sel %0d data 0000/0000", r, o_r1sel, o_r1data, o_r2data, r); end
    end
    i_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_first_issue();
    test_wb_then_issue();
    test_same_cycle();
    test_stall();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
